// File: rtl/uart_receiver.sv
// ---------------------------------------------------------------------------
// uart_receiver
//
// Serial-to-parallel 8N1 UART receiver. The oversample tick from the baud
// rate generator paces every counter and FSM decision. The asynchronous line
// is brought into the clock domain through a two-flop synchroniser. Each bit
// is sampled at its centre. A received byte is presented with a
// ready/acknowledge handshake, together with framing-error and overrun status.
//
// Ports
//   Clock        in   system clock, rising edge
//   Reset        in   synchronous reset, active low
//   uartTick     in   oversample enable, one Clock cycle wide
//   RxD          in   asynchronous serial line, idles high
//   DataAck      in   consumer has taken RxData
//   RxData       out  last received byte
//   DataReady    out  RxData valid and not yet acknowledged
//   FramingError out  last frame's stop bit sampled low
//   Overrun      out  a byte completed while DataReady was still set (sticky)
//   Busy         out  receiver is inside a frame
// ---------------------------------------------------------------------------
module uart_receiver #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 uartTick,
  input  logic                 RxD,
  input  logic                 DataAck,
  output logic [DATA_BITS-1:0] RxData,
  output logic                 DataReady,
  output logic                 FramingError,
  output logic                 Overrun,
  output logic                 Busy
);

  // state  | meaning
  // -------+----------------------------------------------------------
  // IDLE   | line idle, waiting for a low sample on a tick
  // START  | counting to the start-bit centre, re-checking the line low
  // DATA   | sampling DATA_BITS data bits at their centres, LSB first
  // STOP   | sampling the stop bit, then delivering the byte
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

  // synchroniser
  logic                 r_sync1;
  logic                 r_rxs;

  // FSM and datapath state
  state_t               r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [BIT_W-1:0]     r_bitn;
  logic [DATA_BITS-1:0] r_shift;

  // output registers
  logic [DATA_BITS-1:0] r_data;
  logic                 r_ready;
  logic                 r_ferr;
  logic                 r_ovr;
  logic                 r_busy;

  // next-state values
  state_t               w_state_nxt;
  logic [CNT_W-1:0]     w_cnt_nxt;
  logic [BIT_W-1:0]     w_bitn_nxt;
  logic [DATA_BITS-1:0] w_shift_nxt;
  logic                 w_load;

  // -------------------------------------------------------------------------
  // Next-state logic. Nothing moves except on a tick cycle, so line changes
  // between ticks are invisible to the FSM.
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bitn_nxt  = r_bitn;
    w_shift_nxt = r_shift;
    w_load      = 1'b0;

    if (uartTick) begin
      case (r_state)
        S_IDLE: begin
          if (!r_rxs) begin
            w_state_nxt = S_START;
            w_cnt_nxt   = '0;
          end
        end

        S_START: begin
          if (r_cnt == CNT_HALF) begin
            w_cnt_nxt = '0;
            if (!r_rxs) begin
              w_state_nxt = S_DATA;
              w_bitn_nxt  = '0;
            end else begin
              // line went back high before the start-bit centre: glitch
              w_state_nxt = S_IDLE;
            end
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end

        S_DATA: begin
          if (r_cnt == CNT_LAST) begin
            // right shift so the first (LSB) bit ends up at bit 0
            w_shift_nxt = {r_rxs, r_shift[DATA_BITS-1:1]};
            w_cnt_nxt   = '0;
            if (r_bitn == BIT_LAST) begin
              w_state_nxt = S_STOP;
            end else begin
              w_bitn_nxt = r_bitn + 1'b1;
            end
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end

        S_STOP: begin
          if (r_cnt == CNT_LAST) begin
            w_load      = 1'b1;
            w_cnt_nxt   = '0;
            w_state_nxt = S_IDLE;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end

        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // State register, synchroniser and datapath
  // -------------------------------------------------------------------------
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      r_sync1 <= 1'b1;
      r_rxs   <= 1'b1;
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bitn  <= '0;
      r_shift <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_sync1 <= RxD;
      r_rxs   <= r_sync1;
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bitn  <= w_bitn_nxt;
      r_shift <= w_shift_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
    end
  end

  // -------------------------------------------------------------------------
  // Output handshake. A byte completing in the same cycle as an acknowledge
  // takes priority: the acknowledge retires the old byte, so no overrun.
  // -------------------------------------------------------------------------
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      r_data  <= '0;
      r_ready <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
    end else if (w_load) begin
      r_data  <= r_shift;
      r_ready <= 1'b1;
      r_ferr  <= ~r_rxs;
      r_ovr   <= r_ready & ~DataAck;
    end else if (DataAck) begin
      r_ready <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
    end
  end

  assign RxData       = r_data;
  assign DataReady    = r_ready;
  assign FramingError = r_ferr;
  assign Overrun      = r_ovr;
  assign Busy         = r_busy;

endmodule

// File: tb/tb_uart_receiver.sv
// ---------------------------------------------------------------------------
// tb_uart_receiver
//
// Directed bench for uart_receiver at OVERSAMPLE=16, DATA_BITS=8. uartTick
// fires once every 5 clocks, so one bit lasts 80 clocks. Each frame starts
// on the clock edge that follows a consumed tick. With that alignment, the
// start-bit detection tick is consumed 5 edges after the start edge. The
// stop-bit tick is consumed 152 ticks later, at edge 765.
// ---------------------------------------------------------------------------
module tb_uart_receiver;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       uartTick;
  logic       RxD;
  logic       DataAck;
  logic [7:0] RxData;
  logic       DataReady;
  logic       FramingError;
  logic       Overrun;
  logic       Busy;

  logic [2:0] div = 3'd0;

  int n_cmp = 0;
  int n_err = 0;

  uart_receiver #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .uartTick     (uartTick),
    .RxD          (RxD),
    .DataAck      (DataAck),
    .RxData       (RxData),
    .DataReady    (DataReady),
    .FramingError (FramingError),
    .Overrun      (Overrun),
    .Busy         (Busy)
  );

  always #5 Clock = ~Clock;

  always @(posedge Clock) div <= (div == 3'd4) ? 3'd0 : div + 3'd1;
  assign uartTick = (div == 3'd4);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // land #1 after an edge at which div has just returned to 0
  task automatic align();
    do begin
      @(posedge Clock); #1;
    end while (div != 3'd0);
  endtask

  task automatic ack_pulse();
    DataAck = 1'b1;
    @(posedge Clock); #1;
    DataAck = 1'b0;
  endtask

  // One 8N1 frame. If ack_load is set, DataAck is high exactly on the
  // byte-completion cycle. If abort_at >= 0, reset is pulled at that cycle.
  task automatic send_frame(input logic [7:0] b, input logic stop_v, input bit ack_load,
                            input int abort_at, output int rise_at);
    logic prev;
    logic [7:0] bb;
    bb = b;
    rise_at = -1;
    align();
    prev = DataReady;
    for (int cyc = 0; cyc < 800; cyc++) begin
      int seg;
      seg = cyc / 80;
      if (seg == 0)      RxD = 1'b0;
      else if (seg <= 8) RxD = bb[3'(seg - 1)];
      else               RxD = stop_v;
      DataAck = ack_load && (cyc == 764);
      if (abort_at >= 0 && cyc == abort_at) begin
        chk("busy_mid_frame", 32'(Busy), 1);
        Reset   = 1'b0;
        RxD     = 1'b1;
        DataAck = 1'b0;
        repeat (3) @(posedge Clock);
        #1;
        Reset = 1'b1;
        return;
      end
      @(posedge Clock); #1;
      if (!prev && DataReady && rise_at < 0) rise_at = cyc + 1;
      prev = DataReady;
    end
    RxD     = 1'b1;
    DataAck = 1'b0;
    repeat (100) @(posedge Clock);
    #1;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  rise;
    int  fall_at;
    bit  busy_seen;

    // reset
    Reset   = 1'b0;
    RxD     = 1'b1;
    DataAck = 1'b0;
    repeat (3) @(posedge Clock);
    #1;
    chk("rst_rxdata", 32'(RxData),       0);
    chk("rst_ready",  32'(DataReady),    0);
    chk("rst_ferr",   32'(FramingError), 0);
    chk("rst_ovr",    32'(Overrun),      0);
    chk("rst_busy",   32'(Busy),         0);
    Reset = 1'b1;
    repeat (10) @(posedge Clock);
    #1;

    // good frame
    send_frame(8'hA5, 1'b1, 1'b0, -1, rise);
    chk("good_latency_in_window", 32'(rise >= 750 && rise <= 770), 1);
    chk("good_rxdata", 32'(RxData),       'hA5);
    chk("good_ready",  32'(DataReady),    1);
    chk("good_ferr",   32'(FramingError), 0);
    chk("good_busy",   32'(Busy),         0);
    ack_pulse();
    chk("good_ack_ready", 32'(DataReady), 0);

    // false start
    align();
    busy_seen = 1'b0;
    fall_at   = -1;
    for (int cyc = 0; cyc < 60; cyc++) begin
      RxD = (cyc < 20) ? 1'b0 : 1'b1;
      @(posedge Clock); #1;
      if (Busy) busy_seen = 1'b1;
      if (busy_seen && !Busy && fall_at < 0) fall_at = cyc + 1;
    end
    RxD = 1'b1;
    chk("false_busy_pulse",  32'(busy_seen), 1);
    chk("false_busy_window", 32'(fall_at > 0 && fall_at <= 45), 1);
    chk("false_busy_end",    32'(Busy), 0);
    chk("false_ready",       32'(DataReady), 0);
    repeat (20) @(posedge Clock);
    #1;

    // bad stop bit
    send_frame(8'h3C, 1'b0, 1'b0, -1, rise);
    chk("badstop_rxdata", 32'(RxData),       'h3C);
    chk("badstop_ready",  32'(DataReady),    1);
    chk("badstop_ferr",   32'(FramingError), 1);
    ack_pulse();
    chk("badstop_ack_ready", 32'(DataReady),    0);
    chk("badstop_ack_ferr",  32'(FramingError), 0);

    // overrun
    send_frame(8'h11, 1'b1, 1'b0, -1, rise);
    chk("ovr_first_ovr", 32'(Overrun), 0);
    send_frame(8'h22, 1'b1, 1'b0, -1, rise);
    chk("ovr_rxdata", 32'(RxData),    'h22);
    chk("ovr_ready",  32'(DataReady), 1);
    chk("ovr_ovr",    32'(Overrun),   1);
    ack_pulse();
    chk("ovr_ack_ovr",   32'(Overrun),   0);
    chk("ovr_ack_ready", 32'(DataReady), 0);

    // collision: acknowledge on the completion cycle of the second byte
    send_frame(8'h11, 1'b1, 1'b0, -1, rise);
    send_frame(8'h22, 1'b1, 1'b1, -1, rise);
    chk("coll_rxdata", 32'(RxData),       'h22);
    chk("coll_ready",  32'(DataReady),    1);
    chk("coll_ovr",    32'(Overrun),      0);
    chk("coll_ferr",   32'(FramingError), 0);

    // reset in the middle of 8'hFF, with 8'h22 still pending
    send_frame(8'hFF, 1'b1, 1'b0, 400, rise);
    chk("midrst_rxdata", 32'(RxData),       0);
    chk("midrst_ready",  32'(DataReady),    0);
    chk("midrst_ferr",   32'(FramingError), 0);
    chk("midrst_ovr",    32'(Overrun),      0);
    chk("midrst_busy",   32'(Busy),         0);
    repeat (20) @(posedge Clock);
    #1;
    chk("midrst_idle_ready", 32'(DataReady), 0);

    send_frame(8'h5A, 1'b1, 1'b0, -1, rise);
    chk("after_rxdata", 32'(RxData),       'h5A);
    chk("after_ready",  32'(DataReady),    1);
    chk("after_ferr",   32'(FramingError), 0);
    chk("after_ovr",    32'(Overrun),      0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
